// File: rtl/opb_register_bank_ppc2simulink.sv
// OPB slave bank of C_NUM_REGS 32-bit software-to-fabric registers.
// Define OPB_REG_BANK_SHADOW_COMMIT_EN for atomic shadow/commit updates.
module opb_register_bank_ppc2simulink #(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          C_NUM_REGS   = 4,
  parameter logic [31:0] C_RESET_VAL  = 32'h0000_0000
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst,
  input  logic [0:31]             OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:31]             OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:31]             Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  output logic [32*C_NUM_REGS-1:0] user_data_out,
  output logic [C_NUM_REGS-1:0]   user_wr_strobe
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACK,
    S_HOLD
  } state_t;

  localparam logic [5:0] NUM_IDX = 6'(C_NUM_REGS);

  state_t state_q, state_d;

  logic [32:0] lo_diff;
  logic [32:0] hi_diff;
  logic [31:0] offset;
  logic        hit;

  logic [5:0]  idx_q;
  logic        rnw_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  logic        wr_en;
  logic [31:0] rdata;

  logic [31:0]           user_q [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] strobe_q;

  // Borrow bits give the window compare without constant-compare pitfalls.
  assign lo_diff = {1'b0, OPB_ABus} - {1'b0, C_BASEADDR};
  assign hi_diff = {1'b0, C_HIGHADDR} - {1'b0, OPB_ABus};
  assign hit     = OPB_select && !lo_diff[32] && !hi_diff[32];
  assign offset  = lo_diff[31:0];

  logic unused_ok;
  assign unused_ok = ^{OPB_seqAddr, offset[31:8], offset[1:0]};

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (hit) state_d = S_ACK;
      S_ACK:   state_d = S_HOLD;
      default: state_d = S_IDLE;
    endcase
  end

  // Request is captured on the hit edge so a select drop cannot cancel it.
  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      idx_q   <= '0;
      rnw_q   <= 1'b1;
      be_q    <= '0;
      wdata_q <= '0;
    end else if (state_q == S_IDLE && hit) begin
      idx_q   <= offset[7:2];
      rnw_q   <= OPB_RNW;
      be_q    <= OPB_BE;
      wdata_q <= OPB_DBus;
    end
  end

  assign wr_en = (state_q == S_ACK) && !rnw_q;

  function automatic logic [31:0] merge(
    input logic [31:0] old_v,
    input logic [31:0] new_v,
    input logic [3:0]  be
  );
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return r;
  endfunction

`ifdef OPB_REG_BANK_SHADOW_COMMIT_EN

  logic [31:0]           shadow_q [C_NUM_REGS];
  logic [C_NUM_REGS-1:0] pend_q;
  logic                  commit;

  assign commit = wr_en && (idx_q == NUM_IDX) && be_q[0] && wdata_q[0];

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        user_q[i]   <= C_RESET_VAL;
        shadow_q[i] <= C_RESET_VAL;
      end
      pend_q   <= '0;
      strobe_q <= '0;
    end else begin
      strobe_q <= commit ? pend_q : '0;
      if (commit) pend_q <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (commit) user_q[i] <= shadow_q[i];
        if (wr_en && idx_q == 6'(i)) begin
          shadow_q[i] <= merge(shadow_q[i], wdata_q, be_q);
          pend_q[i]   <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (idx_q == 6'(i)) rdata = shadow_q[i];
    end
    if (idx_q == NUM_IDX) rdata = {31'b0, |pend_q};
  end

`else

  always_ff @(posedge OPB_Clk or posedge OPB_Rst) begin
    if (OPB_Rst) begin
      for (int i = 0; i < C_NUM_REGS; i++) begin
        user_q[i] <= C_RESET_VAL;
      end
      strobe_q <= '0;
    end else begin
      strobe_q <= '0;
      for (int i = 0; i < C_NUM_REGS; i++) begin
        if (wr_en && idx_q == 6'(i)) begin
          user_q[i]   <= merge(user_q[i], wdata_q, be_q);
          strobe_q[i] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    rdata = '0;
    for (int i = 0; i < C_NUM_REGS; i++) begin
      if (idx_q == 6'(i)) rdata = user_q[i];
    end
  end

`endif

  for (genvar g = 0; g < C_NUM_REGS; g++) begin : g_out
    assign user_data_out[32*g +: 32] = user_q[g];
  end

  assign user_wr_strobe = strobe_q;
  assign Sl_xferAck     = (state_q == S_ACK);
  assign Sl_DBus        = (state_q == S_ACK && rnw_q) ? rdata : 32'h0;
  assign Sl_errAck      = 1'b0;
  assign Sl_retry       = 1'b0;
  assign Sl_toutSup     = 1'b0;

endmodule

// File: doc/opb_register_bank_ppc2simulink.md
Name: opb_register_bank_ppc2simulink

Overview:
- Parametrised successor to the single-word software-to-fabric register: C_NUM_REGS software-writable, readable 32-bit registers behind one OPB slave window.
- Byte-enable writes, per-register update strobes and an optional atomic shadow/commit path for multi-word updates.
- Sits on the PPC OPB bus.
- Single clock domain (OPB_Clk); the user side consumes outputs synchronously.

Parameters:
- C_BASEADDR, 32'h00000000, window base (word aligned).
- C_HIGHADDR, 32'h000000FF, window top; must cover at least 4*(C_NUM_REGS+1) bytes.
- C_OPB_AWIDTH, 32, OPB address width.
- C_OPB_DWIDTH, 32, OPB data width (only 32 supported).
- C_NUM_REGS, 4, number of user registers, 1..32.
- C_RESET_VAL, 32'h00000000, reset value of every register.

Ports:
- OPB_Clk  in  1  bus and user clock.
- OPB_Rst  in  1  reset; asynchronous, active-high.
- OPB_ABus  in  [0:31]  address.
- OPB_BE  in  [0:3]  byte enables; BE[0] covers DBus[0:7], which is user bits [31:24].
- OPB_DBus  in  [0:31]  write data.
- OPB_RNW  in  1  1 = read.
- OPB_select  in  1  slave select.
- OPB_seqAddr  in  1  ignored.
- Sl_DBus  out  [0:31]  read data; 0 when not acking.
- Sl_xferAck  out  1  transfer acknowledge.
- Sl_errAck, Sl_retry, Sl_toutSup  out  1 each  tied 0.
- user_data_out  out  [32*C_NUM_REGS-1:0]  register i at bits [32i+31:32i].
- user_wr_strobe  out  [C_NUM_REGS-1:0]  one-cycle pulse when register i's output changes value source (any write/commit).

Behaviour:
- Address hit: OPB_select=1 and C_BASEADDR <= OPB_ABus <= C_HIGHADDR.
- Offset = OPB_ABus - C_BASEADDR. idx = offset[7:2]. offset[1:0] are ignored.
- FSM has 3 states:
  - IDLE: Sl_xferAck=0. On hit, go to ACK.
  - ACK: Sl_xferAck=1 for exactly one cycle. Writes take effect at the end of this cycle. Sl_DBus carries read data this cycle only. Next state is HOLD.
  - HOLD: Sl_xferAck=0. Next state is IDLE unconditionally. This absorbs the master's select drop and prevents a double ack.
- Latency: hit sampled on edge N, ack during cycle N+1. A back-to-back or sequential beat costs 3 cycles minimum.
- Write, idx < C_NUM_REGS: only bytes with BE=1 are updated; the others hold.
- Read, idx < C_NUM_REGS: returns the current register value (the shadow value when the feature below is enabled).
- idx == C_NUM_REGS: commit register (see Optional Feature). Without the feature, reads return 0 and writes are ignored.
- idx > C_NUM_REGS inside the window: still acked; reads return 0; writes are ignored with no strobe.
- Sl_DBus is 32'h0 in every non-ACK cycle (OR-bus safe).
- Reset (async, any state, including mid-ACK):
  - state=IDLE, Sl_xferAck=0, Sl_DBus=0, user_wr_strobe=0.
  - All registers and shadows = C_RESET_VAL. The in-flight write is discarded.
- Select dropping during ACK does not cancel the ack or the write.

Optional Feature:
- Macro: OPB_REG_BANK_SHADOW_COMMIT_EN.
- Enabled:
  - OPB writes go to per-register shadow registers; reads return shadows.
  - Writing any data with BE[3]=1 and DBus[31]=1 (user bit 0) to idx == C_NUM_REGS copies every shadow to user_data_out in the same cycle. user_wr_strobe pulses (1 cycle, the cycle after ACK) for every register whose shadow was written since the last commit.
  - Reading idx == C_NUM_REGS returns bit0 = 1 if any uncommitted write is pending.
- Disabled:
  - Writes update user_data_out directly; user_wr_strobe[i] pulses the cycle after the ACK of the write to register i.
  - No commit register.

Test Plan:
- Reset values: assert OPB_Rst with C_RESET_VAL=32'hDEADBEEF, then release -> all user_data_out words = DEADBEEF, Sl_xferAck=0, Sl_DBus=0.
- Full write + readback: write 32'h12345678, BE=1111, offset 0x4 -> ack 1 cycle after select. Word 1 = 12345678 and strobe[1] pulses once (feature off). Read offset 0x4 returns 12345678 on Sl_DBus during ack only.
- Byte enables: register = 32'hAABBCCDD; write 32'h11223344 with BE=0101 -> 32'hAA22CC44.
- Out of range: write 32'hFFFFFFFF to offset 4*(C_NUM_REGS+2) -> acked; no register or strobe change; read returns 0.
- Reset mid-transaction: assert OPB_Rst during the ACK cycle of a write of 32'h5 to offset 0 -> ack drops immediately; word 0 = C_RESET_VAL.
- Feature on: write 32'h1 to offset 0 and 32'h2 to offset 4 -> user_data_out unchanged and commit read = 1. Write commit (32'h1) -> words 0 and 1 update in the same cycle, strobe = 2'b11 for one cycle, commit read = 0.
